demo: RTL and testbench



---
 rtl/demo_pkg.sv | 20 ++
 rtl/demo_pulse_stretch.sv | 39 +++
 rtl/demo.sv | 55 +++++
 tb/tb_demo.sv | 123 ++++++++++++
 4 files changed

// File: rtl/demo_pkg.sv
// Shared constants and helpers for the serial pattern detector.
// Provides default pattern geometry and a constant-time clog2.
package demo_pkg;

    localparam int              DEMO_LEN     = 4;
    localparam logic [DEMO_LEN-1:0] DEMO_PATTERN = 4'b1011;

    // Smallest r with 2**r >= v; used only on elaboration constants.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/demo_pulse_stretch.sv
// Holds the match indication high for STRETCH cycles per trigger.
// Ports: clk, rst (sync, active-high), trig (1-cycle match), out (registered).
module demo_pulse_stretch
    import demo_pkg::*;
#(
    parameter int STRETCH = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic trig,
    output logic out
);

    // At least one bit so STRETCH=1 still yields a legal vector.
    localparam int SW = (clog2(STRETCH) < 1) ? 1 : clog2(STRETCH);
    localparam logic [SW-1:0] RELOAD = SW'(STRETCH - 1);

    logic [SW-1:0] r_scnt;
    logic          r_out;

    // A trigger always reloads, so overlapping pulses merge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_scnt <= '0;
            r_out  <= 1'b0;
        end else if (trig) begin
            r_scnt <= RELOAD;
            r_out  <= 1'b1;
        end else if (r_scnt != '0) begin
            r_scnt <= r_scnt - 1'b1;
            r_out  <= 1'b1;
        end else begin
            r_out  <= 1'b0;
        end
    end

    assign out = r_out;

endmodule

// File: rtl/demo.sv
// Serial bit-stream pattern detector: flags when the last LEN bits equal PATTERN.
// Ports: clk, rst (sync, active-high), a (serial in), w (registered match pulse).
module demo
    import demo_pkg::*;
#(
    parameter int              LEN     = DEMO_LEN,
    parameter logic [LEN-1:0]  PATTERN = DEMO_PATTERN,
    parameter bit              OVERLAP = 1'b1,
    parameter int              STRETCH = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic a,
    output logic w
);

    localparam int CW = clog2(LEN + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(LEN);
    localparam logic [CW-1:0] CNT_LAST = CW'(LEN - 1);

    logic [LEN-1:0] r_hist;
    logic [CW-1:0]  r_cnt;
    logic [LEN-1:0] w_nxt;
    logic           w_full;
    logic           w_match;

    assign w_nxt   = {r_hist[LEN-2:0], a};
    // cnt+1 >= LEN: this bit completes a full window since reset.
    assign w_full  = (r_cnt >= CNT_LAST);
    assign w_match = w_full && (w_nxt == PATTERN);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hist <= '0;
            r_cnt  <= '0;
        end else begin
            r_hist <= w_nxt;
            if (w_match && !OVERLAP) begin
                r_cnt <= '0;
            end else if (r_cnt != CNT_MAX) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    demo_pulse_stretch #(
        .STRETCH (STRETCH)
    ) u_stretch (
        .clk  (clk),
        .rst  (rst),
        .trig (w_match),
        .out  (w)
    );

endmodule

// File: tb/tb_demo.sv
// Directed and randomized checks of the pattern detector across parameter sets.
// Four instances: defaults, OVERLAP=0, PATTERN=0000, STRETCH=3.
module tb_demo;

    logic       clk = 1'b0;
    logic [3:0] rst = 4'hF;
    logic [3:0] a   = 4'h0;
    logic [3:0] w;

    typedef struct {
        int    d;
        logic  e;
        string tag;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    // Reference state for the random phase on instance 3.
    bit   mbits[$];
    int   mage;

    always #5 clk = ~clk;

    demo u0 (.clk(clk), .rst(rst[0]), .a(a[0]), .w(w[0]));

    demo #(.OVERLAP(1'b0)) u1 (
        .clk(clk), .rst(rst[1]), .a(a[1]), .w(w[1]));

    demo #(.PATTERN(4'b0000)) u2 (
        .clk(clk), .rst(rst[2]), .a(a[2]), .w(w[2]));

    demo #(.STRETCH(3)) u3 (
        .clk(clk), .rst(rst[3]), .a(a[3]), .w(w[3]));

    task automatic step(input int d, input logic r, input logic av,
                        input logic ex, input string tag);
        exp_t e;
        exp_t got;
        @(negedge clk);
        rst[d] = r;
        a[d]   = av;
        e.d = d;
        e.e = ex;
        e.tag = tag;
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        checks++;
        assert (w[got.d] === got.e) else begin
            errors++;
            $error("FAIL %s: w=%b expected %b", got.tag, w[got.d], got.e);
        end
    endtask

    task automatic rstc(input int d, input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            step(d, 1'b1, 1'bx, 1'b0, tag);
        end
    endtask

    // bits/exps are written oldest-first in the MSB of an n-bit field.
    task automatic seq(input int d, input int n, input logic [31:0] bits,
                       input logic [31:0] exps, input string tag);
        for (int i = 0; i < n; i++) begin
            step(d, 1'b0, bits[n-1-i], exps[n-1-i],
                 $sformatf("%s[%0d]", tag, i + 1));
        end
    endtask

    function automatic logic model_push(input bit b);
        bit hit;
        mbits.push_back(b);
        hit = 1'b0;
        if (mbits.size() >= 4) begin
            hit = mbits[$-3] && !mbits[$-2] && mbits[$-1] && mbits[$];
        end
        if (hit) mage = 0;
        else     mage++;
        return (mage < 3);
    endfunction

    initial begin
        bit b;
        logic ex;

        rstc(0, 5, "t1_reset");
        seq(0, 6, 32'b101100, 32'b000100, "t1_basic");

        rstc(0, 1, "t2_reset");
        seq(0, 7, 32'b1011011, 32'b0001001, "t2_overlap");

        rstc(1, 2, "t3_reset");
        seq(1, 7, 32'b1011011, 32'b0001000, "t3_noovl");
        seq(1, 4, 32'b1011, 32'b0001, "t3_fresh");

        rstc(2, 2, "t4_reset");
        seq(2, 7, 32'b0000000, 32'b0001111, "t4_fill");

        rstc(0, 1, "t5_reset");
        seq(0, 3, 32'b101, 32'b000, "t5_part");
        rstc(0, 1, "t5_midrst");
        seq(0, 4, 32'b1011, 32'b0001, "t5_after");

        rstc(3, 2, "t6_reset");
        seq(3, 10, 32'b1011011000, 32'b0001111110, "t6_stretch");

        mbits.delete();
        mage = 1000;
        rstc(3, 5, "t7_reset");
        for (int i = 0; i < 50; i++) begin
            b  = 1'($urandom_range(0, 1));
            ex = model_push(b);
            step(3, 1'b0, b, ex, $sformatf("t7_rand[%0d]", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
